// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-fronted RAM command controller.
// Frame layout, command codes and FSM state encoding.
// Imported by the controller top and its RAM.
package spi_ram_pkg;

  // Received frame: [9:8] command, [7:0] payload
  localparam int FRAME_W   = 10;
  localparam int CMD_MSB   = 9;
  localparam int CMD_LSB   = 8;
  localparam int PAYLOAD_W = CMD_LSB;

  // Command codes carried in the top two frame bits
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPI_RD  = 2'd1,
    SPI_TX  = 2'd2,
    HOST_RD = 2'd3
  } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, one-cycle registered read, no reset.
// Latency: rdata reflects the address presented at the previous rising edge.
// Out-of-range addresses: writes dropped, reads return zero.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  in_range;

  // Address range check shared by the write and read paths
  always_comb begin
    in_range = ({1'b0, addr} < DEPTH_LIM);
  end

  // Storage write and registered read; read kept inside the clocked block so
  // the array maps onto a synchronous RAM macro
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= in_range ? mem_q[addr] : '0;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI frames into RAM address/write/read operations and shares the port with a host.
// Latency: SPI read -> tx_valid 2 cycles after accept edge; host write ack +1, host read ack +2.
// SPI has priority; frames arriving while busy are dropped with a cmd_drop strobe.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_W-1:0]    rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  output logic                  cmd_drop
);

  state_t                state_q, state_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic                  host_ack_q, host_ack_d;
  logic                  cmd_drop_q, cmd_drop_d;

  logic                  accept;
  logic [1:0]            cmd;
  logic [PAYLOAD_W-1:0]  payload;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Frame decode; a frame is taken only on the rising edge of rx_valid
  always_comb begin
    rx_valid_d = rx_valid;
    accept     = rx_valid & ~rx_valid_q;
    cmd        = rx_data[CMD_MSB:CMD_LSB];
    payload    = rx_data[CMD_LSB-1:0];
  end

  // Next-state, RAM port arbitration and output strobes
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    host_ack_d   = 1'b0;
    cmd_drop_d   = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = rd_addr_q;
    mem_wdata    = DATA_WIDTH'(payload);

    case (state_q)
      IDLE: begin
        if (accept) begin
          // SPI frame wins the port; any host request waits
          case (cmd)
            CMD_WR_ADDR: wr_addr_d = ADDR_WIDTH'(payload);
            CMD_WR_DATA: begin
              mem_we    = 1'b1;
              mem_addr  = wr_addr_q;
              mem_wdata = DATA_WIDTH'(payload);
            end
            CMD_RD_ADDR: rd_addr_d = ADDR_WIDTH'(payload);
            default: begin
              mem_addr = rd_addr_q;
              state_d  = SPI_RD;
            end
          endcase
        end else if (host_req && !host_ack_q) begin
          // host_req is still high during its own ack cycle; do not re-grant it
          mem_addr = host_addr;
          if (host_we) begin
            mem_we     = 1'b1;
            mem_wdata  = host_wdata;
            host_ack_d = 1'b1;
          end else begin
            state_d = HOST_RD;
          end
        end
      end
      SPI_RD: begin
        tx_data_d = mem_rdata;
        state_d   = SPI_TX;
      end
      SPI_TX: begin
        tx_valid_d = 1'b1;
        state_d    = IDLE;
      end
      HOST_RD: begin
        host_rdata_d = mem_rdata;
        host_ack_d   = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A frame landing while an operation is in flight is discarded
    if (accept && (state_q != IDLE)) begin
      cmd_drop_d = 1'b1;
    end
  end

  // State and registered outputs; reset cancels any pending strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      host_rdata_q <= '0;
      host_ack_q   <= 1'b0;
      cmd_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_valid_q   <= rx_valid_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
      cmd_drop_q   <= cmd_drop_d;
    end
  end

  spi_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q;
  assign cmd_drop   = cmd_drop_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a full-depth and a 200-word instance share stimulus.
// Table of SPI frames with expected read data, then hand sequences for corner cases.
// Outputs sampled 1 time unit after the rising edge.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       reset;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;

  logic [7:0] tx_data,    tx_data2;
  logic       tx_valid,   tx_valid2;
  logic [7:0] host_rdata, host_rdata2;
  logic       host_ack,   host_ack2;
  logic       cmd_drop,   cmd_drop2;

  int n_cmp = 0;
  int n_err = 0;
  int tx_cnt = 0, tx_cnt2 = 0, drop_cnt = 0, drop_cnt2 = 0;

  spi_ram_ctrl dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .cmd_drop(cmd_drop)
  );

  spi_ram_ctrl #(.MEM_DEPTH(200)) dut200 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data2), .tx_valid(tx_valid2),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata2), .host_ack(host_ack2),
    .cmd_drop(cmd_drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters, sampled mid-cycle
  always @(negedge clk) begin
    if (tx_valid)  tx_cnt++;
    if (tx_valid2) tx_cnt2++;
    if (cmd_drop)  drop_cnt++;
    if (cmd_drop2) drop_cnt2++;
  end

  typedef struct {
    logic [9:0] frame;
    logic [7:0] exp;
    logic [7:0] exp200;
  } vec_t;

  vec_t tbl[36];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 unit after the accept edge with rx_valid already low again
  task automatic send_frame(input logic [9:0] f);
    @(posedge clk);
    #1 rx_data = f;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Called right after send_frame of a RD_DATA; k counts edges after the accept edge
  task automatic rd_check(input string nm, input logic [7:0] e, input logic [7:0] e2);
    int k1, k2, p1, p2;
    logic [7:0] d1, d2;
    k1 = -1; k2 = -1; p1 = 0; p2 = 0; d1 = '0; d2 = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (tx_valid) begin
        p1++;
        if (k1 < 0) begin k1 = k; d1 = tx_data; end
      end
      if (tx_valid2) begin
        p2++;
        if (k2 < 0) begin k2 = k; d2 = tx_data2; end
      end
    end
    chk({nm, " tx lat"}, k1, 2);
    chk({nm, " tx lat200"}, k2, 2);
    chk({nm, " tx pulses"}, p1, 1);
    chk({nm, " tx data"}, d1, e);
    chk({nm, " tx data200"}, d2, e2);
  endtask

  // Host access; latency counted in edges after the request was raised
  task automatic host_op(input string nm, input logic we, input logic [7:0] a,
                         input logic [7:0] wd, input int exp_lat,
                         input logic [7:0] e, input logic [7:0] e2);
    int l1, l2;
    logic [7:0] d1, d2;
    l1 = -1; l2 = -1; d1 = '0; d2 = '0;
    @(posedge clk);
    #1 host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = wd;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (host_ack && l1 < 0) begin l1 = k; d1 = host_rdata; end
      if (host_ack2 && l2 < 0) begin l2 = k; d2 = host_rdata2; end
      if (l1 >= 0 || l2 >= 0) host_req = 1'b0;
    end
    host_req = 1'b0;
    host_we = 1'b0;
    chk({nm, " ack lat"}, l1, exp_lat);
    chk({nm, " ack lat200"}, l2, exp_lat);
    if (!we) begin
      chk({nm, " rdata"}, d1, e);
      chk({nm, " rdata200"}, d2, e2);
    end
  endtask

  initial begin
    int t0, t2, d0, d2, ktx, kack, kdrop;
    logic [7:0] dtx;

    // SPI frame table: {frame, expected tx (full depth), expected tx (200 deep)}
    tbl[0]  = '{10'h012, 8'h00, 8'h00};
    tbl[1]  = '{10'h1A5, 8'h00, 8'h00};
    tbl[2]  = '{10'h212, 8'h00, 8'h00};
    tbl[3]  = '{10'h300, 8'hA5, 8'hA5};
    tbl[4]  = '{10'h080, 8'h00, 8'h00};
    tbl[5]  = '{10'h15A, 8'h00, 8'h00};
    tbl[6]  = '{10'h013, 8'h00, 8'h00};
    tbl[7]  = '{10'h1C3, 8'h00, 8'h00};
    tbl[8]  = '{10'h280, 8'h00, 8'h00};
    tbl[9]  = '{10'h300, 8'h5A, 8'h5A};
    tbl[10] = '{10'h300, 8'h5A, 8'h5A};
    tbl[11] = '{10'h213, 8'h00, 8'h00};
    tbl[12] = '{10'h3FF, 8'hC3, 8'hC3};
    tbl[13] = '{10'h212, 8'h00, 8'h00};
    tbl[14] = '{10'h300, 8'hA5, 8'hA5};
    tbl[15] = '{10'h020, 8'h00, 8'h00};
    tbl[16] = '{10'h111, 8'h00, 8'h00};
    tbl[17] = '{10'h122, 8'h00, 8'h00};
    tbl[18] = '{10'h220, 8'h00, 8'h00};
    tbl[19] = '{10'h300, 8'h22, 8'h22};
    tbl[20] = '{10'h0F0, 8'h00, 8'h00};
    tbl[21] = '{10'h155, 8'h00, 8'h00};
    tbl[22] = '{10'h2F0, 8'h00, 8'h00};
    tbl[23] = '{10'h300, 8'h55, 8'h00};
    tbl[24] = '{10'h000, 8'h00, 8'h00};
    tbl[25] = '{10'h166, 8'h00, 8'h00};
    tbl[26] = '{10'h0C7, 8'h00, 8'h00};
    tbl[27] = '{10'h177, 8'h00, 8'h00};
    tbl[28] = '{10'h200, 8'h00, 8'h00};
    tbl[29] = '{10'h300, 8'h66, 8'h66};
    tbl[30] = '{10'h2C7, 8'h00, 8'h00};
    tbl[31] = '{10'h300, 8'h77, 8'h77};
    tbl[32] = '{10'h0C8, 8'h00, 8'h00};
    tbl[33] = '{10'h1EE, 8'h00, 8'h00};
    tbl[34] = '{10'h2C8, 8'h00, 8'h00};
    tbl[35] = '{10'h300, 8'hEE, 8'h00};

    reset = 1'b1;
    rx_data = '0;
    rx_valid = 1'b0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {tx_data, tx_valid, host_rdata, host_ack, cmd_drop}, 0);
    chk("reset outs200", {tx_data2, tx_valid2, host_rdata2, host_ack2, cmd_drop2}, 0);
    reset = 1'b0;
    idle(3);

    for (int i = 0; i < 36; i++) begin
      send_frame(tbl[i].frame);
      if (tbl[i].frame[9:8] == 2'b11) begin
        rd_check($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].exp200);
        idle(4);
      end else begin
        idle(10);
      end
    end

    // Held rx_valid level: one write, one read
    send_frame(10'h000);
    idle(10);
    d0 = drop_cnt; d2 = drop_cnt2;
    @(posedge clk);
    #1 rx_data = 10'h13C;
    rx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 rx_valid = 1'b0;
    idle(10);
    chk("held wr no drop", drop_cnt - d0, 0);
    host_op("held wr host rd", 1'b0, 8'h00, 8'h00, 2, 8'h3C, 8'h3C);
    send_frame(10'h200);
    idle(10);
    t0 = tx_cnt; t2 = tx_cnt2;
    @(posedge clk);
    #1 rx_data = 10'h300;
    rx_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 rx_valid = 1'b0;
    idle(10);
    chk("held rd pulses", tx_cnt - t0, 1);
    chk("held rd pulses200", tx_cnt2 - t2, 1);
    chk("held rd data", tx_data, 8'h3C);
    chk("held rd no drop", drop_cnt2 - d2, 0);

    // Host access around the 200-word boundary
    host_op("host wr C8", 1'b1, 8'hC8, 8'hAB, 1, 8'h00, 8'h00);
    host_op("host rd C8", 1'b0, 8'hC8, 8'h00, 2, 8'hAB, 8'h00);
    host_op("host rd F0", 1'b0, 8'hF0, 8'h00, 2, 8'h55, 8'h00);

    // Host write raised in the same cycle as an RD_DATA accept
    send_frame(10'h212);
    idle(10);
    @(posedge clk);
    #1 rx_data = 10'h300;
    rx_valid = 1'b1;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 8'h40;
    host_wdata = 8'h07;
    ktx = -1; kack = -1; dtx = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 rx_valid = 1'b0;
      if (tx_valid && ktx < 0) begin ktx = k; dtx = tx_data; end
      if (host_ack && kack < 0) begin kack = k; host_req = 1'b0; end
    end
    host_req = 1'b0;
    host_we = 1'b0;
    chk("arb tx lat", ktx, 2);
    chk("arb tx data", dtx, 8'hA5);
    chk("arb host ack lat", kack, 3);
    idle(4);
    send_frame(10'h240);
    idle(10);
    send_frame(10'h300);
    rd_check("arb rd 40", 8'h07, 8'h07);
    idle(4);

    // Frame arriving while a read is in flight is dropped
    send_frame(10'h220);
    idle(10);
    d0 = drop_cnt;
    @(posedge clk);
    #1 rx_data = 10'h300;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk);
    #1 rx_data = 10'h212;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    kdrop = {31'd0, cmd_drop};
    chk("busy drop strobe", {cmd_drop, cmd_drop2, tx_valid, tx_data}, {3'b111, 8'h22});
    idle(1);
    chk("busy drop cleared", {cmd_drop, cmd_drop2, tx_valid}, 3'b000);
    idle(8);
    chk("busy drop count", drop_cnt - d0, kdrop);
    chk("busy drop single", drop_cnt - d0, 1);
    send_frame(10'h300);
    rd_check("busy rd again", 8'h22, 8'h22);
    idle(4);

    // Reset asserted while the read is in SPI_RD
    @(posedge clk);
    #1 rx_data = 10'h300;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid rst outs", {tx_data, tx_valid, host_rdata, host_ack, cmd_drop}, 0);
    chk("mid rst outs200", {tx_data2, tx_valid2, host_rdata2, host_ack2, cmd_drop2}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    t0 = tx_cnt;
    idle(8);
    chk("mid rst no tx", tx_cnt - t0, 0);
    send_frame(10'h199);
    idle(10);
    send_frame(10'h300);
    rd_check("post rst addr0", 8'h99, 8'h99);
    idle(4);
    send_frame(10'h240);
    idle(10);
    send_frame(10'h300);
    rd_check("post rst rd 40", 8'h07, 8'h07);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Command controller behind the SPI slave.
- Decodes each 10-bit received frame (2-bit command + 8-bit payload) into address-latch, write or read operations on a single-port synchronous RAM.
- Returns read data to the slave's transmit side.
- Arbitrates the same RAM port with a local host requester; SPI has priority.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM word width; fixed equal to the payload width.
- MEM_DEPTH, 256, number of words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  10  frame from the SPI slave; [9:8] command, [7:0] payload.
- rx_valid  in  1  frame valid from the SPI slave; may stay high for more than one cycle.
- tx_data  out  8  read data to the SPI slave.
- tx_valid  out  1  one-cycle strobe; tx_data is valid.
- host_req  in  1  host access request; held until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  in  ADDR_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host write data.
- host_rdata  out  DATA_WIDTH  host read data; valid with host_ack.
- host_ack  out  1  one-cycle completion strobe.
- cmd_drop  out  1  one-cycle strobe; an SPI frame was discarded.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - tx_data=0, tx_valid=0, host_rdata=0, host_ack=0, cmd_drop=0.
  - wr_addr=0, rd_addr=0, state=IDLE.
  - RAM contents are not reset.
- Frame accept: on the rising edge of rx_valid only (rx_valid registered as rx_valid_q; accept = rx_valid & ~rx_valid_q). A held level counts as one frame.
- Command codes:
  - 00: WR_ADDR. wr_addr ← payload. No RAM access.
  - 01: WR_DATA. RAM[wr_addr] ← payload. wr_addr is unchanged.
  - 10: RD_ADDR. rd_addr ← payload. No RAM access.
  - 11: RD_DATA. Read RAM[rd_addr]; return the word on tx_data.
- FSM states: IDLE, SPI_RD, SPI_TX, HOST_RD.
  - IDLE, accepted frame: WR_ADDR, RD_ADDR and WR_DATA complete in that cycle (WR_DATA writes the RAM at that edge); stay in IDLE. RD_DATA issues the RAM read and goes to SPI_RD.
  - IDLE, no frame, host_req=1: a host write happens at that edge, host_ack pulses the next cycle, stay in IDLE. A host read is issued and goes to HOST_RD.
  - SPI_RD → SPI_TX: register RAM output into tx_data.
  - SPI_TX: tx_valid=1 for exactly this cycle; go to IDLE.
  - HOST_RD: host_rdata ← RAM output; host_ack=1 this cycle; go to IDLE.
- Latency:
  - SPI RD_DATA: tx_valid is high in the 3rd cycle after the accept cycle (accept edge N; tx_valid high between edges N+2 and N+3).
  - Host write: ack 1 cycle after grant.
  - Host read: ack 2 cycles after grant.
- Arbitration:
  - Accepted frame and host_req in the same IDLE cycle: SPI wins, host waits.
  - Host is granted only in IDLE with no frame that cycle.
  - SPI frames are spaced ≥10 cycles, so the host cannot starve.
- Busy collision: a frame accepted while state ≠ IDLE is discarded, cmd_drop pulses one cycle, no state change. This occurs only under abnormal SPI timing.
- Out-of-range address (address ≥ MEM_DEPTH): writes are ignored; reads return 0. Applies to both SPI and host.
- Host write and SPI write to the same address in the same cycle cannot occur (SPI wins, host is deferred).
- tx_data holds its last value between strobes.
- Reset mid-operation: pending tx_valid or host_ack is cancelled. The host must re-issue its request after reset falls.

Decomposition:
- Package spi_ram_pkg:
  - command code constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FSM state encoding;
  - frame field positions (CMD_MSB=9, CMD_LSB=8).
- One sub-module, spi_ram_mem: single-port synchronous RAM with ports clk, we, addr, wdata, rdata; one-cycle read latency; no reset; parameterised by ADDR_WIDTH, DATA_WIDTH, MEM_DEPTH.

Test Plan:
- Reset asserted mid-SPI_RD → all outputs 0 immediately; no tx_valid after reset release; next RD_DATA returns correct data.
- Frames 0x0_12 (WR_ADDR 0x12), then 0x1_A5, then 0x2_12, then 0x3_00 → tx_data=0xA5 with a single-cycle tx_valid exactly 2 cycles after the 4th accept edge.
- rx_valid held high 5 cycles with frame 0x1_3C after WR_ADDR 0x00 → exactly one write; host read of addr 0x00 returns host_rdata=0x3C with host_ack 2 cycles after grant.
- host_req (write 0x07→addr 0x40) rising in the same cycle as accept of RD_DATA → SPI read completes first; host_ack delayed until return to IDLE; subsequent SPI read of 0x40 returns 0x07.
- Second rx_valid rising edge forced one cycle after an RD_DATA accept → cmd_drop=1 for one cycle; first read still returns correct tx_data.
- MEM_DEPTH=200: WR_ADDR 0xF0, WR_DATA 0x55, RD_ADDR 0xF0, RD_DATA → tx_data=0x00; addresses 0 and 199 read back written values.
